// File: rtl/dnn_seq_ctrl.sv
// Operand sequencer for a small DNN datapath: streams a 28-word batch (or a 4-word
// x-only batch when weights are reused), strobes the datapath, then collects two results.
module dnn_seq_ctrl #(
  parameter int IN_HOLD = 5,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [4:0]  s_data,
  input  logic               cfg_keep_w,
  output logic [19:0]        dp_x,
  output logic [79:0]        dp_w1,
  output logic [39:0]        dp_w2,
  output logic               dp_in_ready,
  input  logic signed [16:0] dp_out0,
  input  logic signed [16:0] dp_out1,
  input  logic               dp_out0_ready,
  input  logic               dp_out1_ready,
  output logic               r_valid,
  input  logic               r_ready,
  output logic signed [16:0] r_out0,
  output logic signed [16:0] r_out1,
  output logic               r_timeout,
  output logic               busy
);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, RESULT} state_t;

  state_t     state, state_nxt;
  logic [4:0] cnt;
  logic [3:0] hold_cnt;
  logic [7:0] wait_cnt;
  logic       short_batch, w_loaded, got0, got1;
  logic       accept, is_short, last_word, take0, take1, both, wait_expired, hold_done, r_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    s_ready      = 1'b0;
    dp_in_ready  = 1'b0;
    r_valid      = 1'b0;
    accept       = 1'b0;
    take0        = 1'b0;
    take1        = 1'b0;
    both         = 1'b0;
    wait_expired = 1'b0;
    hold_done    = 1'b0;
    r_fire       = 1'b0;
    // Batch length is decided by the first word; afterwards the latched choice applies.
    is_short     = (cnt == 5'd0) ? (cfg_keep_w & w_loaded) : short_batch;
    last_word    = is_short ? (cnt == 5'd3) : (cnt == 5'd27);
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (accept && last_word) state_nxt = FIRE;
      end
      FIRE: begin
        dp_in_ready = 1'b1;
        take0       = dp_out0_ready & ~got0;
        take1       = dp_out1_ready & ~got1;
        hold_done   = (hold_cnt == 4'(IN_HOLD - 1));
        if (hold_done) state_nxt = WAIT;
      end
      WAIT: begin
        take0        = dp_out0_ready & ~got0;
        take1        = dp_out1_ready & ~got1;
        both         = (got0 | dp_out0_ready) & (got1 | dp_out1_ready);
        wait_expired = (wait_cnt == 8'(TIMEOUT - 1));
        if (both || wait_expired) state_nxt = RESULT;
      end
      RESULT: begin
        r_valid = 1'b1;
        r_fire  = r_ready;
        if (r_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign busy = !((state == LOAD) && (cnt == 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 5'd0;
      short_batch <= 1'b0;
      w_loaded    <= 1'b0;
      hold_cnt    <= 4'd0;
      wait_cnt    <= 8'd0;
      got0        <= 1'b0;
      got1        <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (accept) begin
        if (cnt == 5'd0) short_batch <= is_short;
        if (last_word) begin
          cnt <= 5'd0;
          if (!is_short) w_loaded <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
      hold_cnt <= (state == FIRE) ? hold_cnt + 4'd1 : 4'd0;
      wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (take0) got0 <= 1'b1;
      if (take1) got1 <= 1'b1;
      if ((state == WAIT) && (state_nxt == RESULT)) r_timeout <= !both;
      if (r_fire) begin
        got0      <= 1'b0;
        got1      <= 1'b0;
        r_timeout <= 1'b0;
      end
    end
  end

  // Operand registers: slot chosen by word index, x first, then w1 block, then w2 block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_x   <= '0;
      dp_w1  <= '0;
      dp_w2  <= '0;
      r_out0 <= '0;
      r_out1 <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 4; i++)
          if (cnt == 5'(i)) dp_x[19 - 5*i -: 5] <= s_data;
        for (int i = 0; i < 16; i++)
          if (cnt == 5'(i + 4)) dp_w1[79 - 5*i -: 5] <= s_data;
        for (int i = 0; i < 8; i++)
          if (cnt == 5'(i + 20)) dp_w2[39 - 5*i -: 5] <= s_data;
      end
      if (take0) r_out0 <= dp_out0;
      if (take1) r_out1 <= dp_out1;
      // Clear on hand-off so a result that never arrives in the next batch reads 0.
      if (r_fire) begin
        r_out0 <= '0;
        r_out1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dnn_seq_ctrl.sv
// Randomized bench for dnn_seq_ctrl: a word-array model of the operand slots plus a
// timing model of the datapath result window predicts every handshake and captured value.
module tb_dnn_seq_ctrl;
  localparam int IN_HOLD = 5;
  localparam int TIMEOUT = 64;
  localparam int WIN     = IN_HOLD + TIMEOUT - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid, s_ready, cfg_keep_w;
  logic signed [4:0]  s_data;
  logic [19:0]        dp_x;
  logic [79:0]        dp_w1;
  logic [39:0]        dp_w2;
  logic               dp_in_ready;
  logic signed [16:0] dp_out0, dp_out1;
  logic               dp_out0_ready, dp_out1_ready;
  logic               r_valid, r_ready, r_timeout, busy;
  logic signed [16:0] r_out0, r_out1;

  always #5 clk = ~clk;

  dnn_seq_ctrl #(.IN_HOLD(IN_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .cfg_keep_w(cfg_keep_w),
    .dp_x(dp_x), .dp_w1(dp_w1), .dp_w2(dp_w2), .dp_in_ready(dp_in_ready),
    .dp_out0(dp_out0), .dp_out1(dp_out1),
    .dp_out0_ready(dp_out0_ready), .dp_out1_ready(dp_out1_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_out0(r_out0), .r_out1(r_out1),
    .r_timeout(r_timeout), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] mdl_x [4];
  logic [4:0] mdl_w [24];
  bit         mdl_w_loaded;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] exp_x();
    logic [19:0] v = '0;
    for (int i = 0; i < 4; i++) v = {v[14:0], mdl_x[i]};
    return v;
  endfunction

  function automatic logic [79:0] exp_w1();
    logic [79:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[74:0], mdl_w[i]};
    return v;
  endfunction

  function automatic logic [39:0] exp_w2();
    logic [39:0] v = '0;
    for (int i = 16; i < 24; i++) v = {v[34:0], mdl_w[i]};
    return v;
  endfunction

  function automatic int rand_d();
    int r = int'($urandom_range(0, 15));
    if (r == 0) return -1;
    if (r == 1) return int'($urandom_range(WIN - 2, WIN + 3));
    return int'($urandom_range(0, IN_HOLD + 10));
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++)  mdl_x[i] = '0;
    for (int i = 0; i < 24; i++) mdl_w[i] = '0;
    mdl_w_loaded = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_in_ready", dp_in_ready, 1'b0);
    chk("rst_r_timeout", r_timeout, 1'b0);
    chk("rst_r_out0", r_out0, 17'sd0);
    chk("rst_r_out1", r_out1, 17'sd0);
    chk("rst_dp_x", dp_x, 20'd0);
    chk("rst_dp_w1", dp_w1, 80'd0);
    chk("rst_dp_w2", dp_w2, 40'd0);
  endtask

  // mode: 0 random words, 1 all ones, 2 x = 2,3,4,5. d0/d1: cycle (from first FIRE
  // cycle) of the first ready pulse, -1 for never.
  task automatic run_batch(input bit keep, input int mode, input int d0, input int d1,
                           input logic signed [16:0] v0, input logic signed [16:0] v1,
                           input int hold);
    logic [4:0] words [28];
    int n_len, k, cyc, m, exp_res;
    bit e0, e1, tmo, acc;
    logic signed [16:0] x0, x1;
    for (int i = 0; i < 28; i++) words[i] = 5'($urandom_range(0, 31));
    if (mode == 1) for (int i = 0; i < 28; i++) words[i] = 5'd1;
    if (mode == 2) for (int i = 0; i < 4; i++) words[i] = 5'(i + 2);
    n_len = (keep && mdl_w_loaded) ? 4 : 28;

    k = 0;
    cyc = 0;
    while (k < n_len && cyc < 400) begin
      chk("ld_s_ready", s_ready, 1'b1);
      chk("ld_busy", busy, k != 0);
      s_valid    = ($urandom_range(0, 3) != 0);
      s_data     = words[k];
      cfg_keep_w = (k == 0) ? keep : 1'($urandom_range(0, 1));
      r_ready    = 1'($urandom_range(0, 1));
      acc        = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    if (k < n_len) chk("ld_budget", 80'(k), 80'(n_len));

    for (int i = 0; i < 4; i++) mdl_x[i] = words[i];
    if (n_len == 28) begin
      for (int i = 0; i < 24; i++) mdl_w[i] = words[i + 4];
      mdl_w_loaded = 1'b1;
    end

    e0 = (d0 >= 0) && (d0 <= WIN);
    e1 = (d1 >= 0) && (d1 <= WIN);
    if (e0 && e1) begin
      m       = (d0 > d1) ? d0 : d1;
      exp_res = ((m > IN_HOLD) ? m : IN_HOLD) + 1;
      tmo     = 1'b0;
    end else begin
      exp_res = IN_HOLD + TIMEOUT;
      tmo     = 1'b1;
    end
    x0 = e0 ? v0 : 17'sd0;
    x1 = e1 ? v1 : 17'sd0;

    for (int c = 0; c < exp_res; c++) begin
      chk("fw_in_ready", dp_in_ready, c < IN_HOLD);
      chk("fw_ctl", {s_ready, busy, r_valid}, 3'b010);
      dp_out0_ready = (c == d0) || (d0 >= 0 && c > d0 && $urandom_range(0, 3) == 0);
      dp_out1_ready = (c == d1) || (d1 >= 0 && c > d1 && $urandom_range(0, 3) == 0);
      dp_out0       = (c == d0) ? v0 : 17'($urandom);
      dp_out1       = (c == d1) ? v1 : 17'($urandom);
      s_valid       = 1'($urandom_range(0, 1));
      s_data        = 5'($urandom);
      cfg_keep_w    = 1'($urandom_range(0, 1));
      r_ready       = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    dp_out0_ready = 1'b0;
    dp_out1_ready = 1'b0;
    r_ready       = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      chk("res_ctl", {r_valid, s_ready, dp_in_ready, busy}, 4'b1001);
      chk("res_out0", r_out0, x0);
      chk("res_out1", r_out1, x1);
      chk("res_timeout", r_timeout, tmo);
      chk("res_dp_x", dp_x, exp_x());
      chk("res_dp_w1", dp_w1, exp_w1());
      chk("res_dp_w2", dp_w2, exp_w2());
      r_ready = (h == hold);
      s_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    r_ready = 1'b0;
    s_valid = 1'b0;
    chk("xfer_ctl", {r_valid, s_ready, busy}, 3'b010);
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; cfg_keep_w = 1'b0; r_ready = 1'b0;
    dp_out0 = '0; dp_out1 = '0; dp_out0_ready = 1'b0; dp_out1_ready = 1'b0;
    mdl_reset();
    #12;
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset();

    run_batch(1'b0, 1, IN_HOLD + 3, IN_HOLD + 3, 17'sd123, -17'sd45, 2);
    run_batch(1'b1, 2, IN_HOLD, IN_HOLD, 17'($urandom), 17'($urandom), 1);
    run_batch(1'($urandom_range(0, 1)), 0, IN_HOLD + 2, IN_HOLD + 7,
              17'($urandom), 17'($urandom), 0);
    run_batch(1'b1, 0, IN_HOLD + 1, -1, -17'sd7, 17'sd99, 10);
    run_batch(1'b0, 0, 1, 3, 17'($urandom), 17'($urandom), 3);

    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1; s_data = 5'($urandom); cfg_keep_w = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_reset();
    @(posedge clk); #1;
    chk_reset();
    run_batch(1'b1, 0, IN_HOLD + 4, IN_HOLD + 1, 17'($urandom), 17'($urandom), 1);

    for (int b = 0; b < 20; b++)
      run_batch(1'($urandom_range(0, 1)), 0, rand_d(), rand_d(),
                17'($urandom), 17'($urandom), int'($urandom_range(0, 4)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
